// File: rtl/rf_update_sched_pkg.sv
// rf_update_sched_pkg
//   Shared constants for the register-file write scheduler slice:
//   default widths/depth for the reg index, ROB tag, data and commit FIFO,
//   plus a helper that sizes occupancy counters.
package rf_update_sched_pkg;

  localparam int unsigned CMT_DEPTH_DEF  = 4;
  localparam int unsigned ROB_IDX_W_DEF  = 4;
  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF     = 32;

  localparam logic FALSE = 1'b0;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rf_cmt_fifo.sv
// rf_cmt_fifo
//   Synchronous FIFO, asynchronous active-high reset, power-of-2 depth.
//   Pointers wrap naturally; the occupancy counter separates full from empty.
//   A push while full is accepted only together with a pop.
// Ports:
//   clk, rst         clock / async reset
//   push, din        write request and data
//   pop, dout        read request; dout shows the current head
//   full, empty      status flags
//   count            occupancy 0..DEPTH
module rf_cmt_fifo
  import rf_update_sched_pkg::*;
#(
  parameter int unsigned DEPTH = CMT_DEPTH_DEF,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [cnt_w(DEPTH)-1:0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rf_update_sched.sv
// rf_update_sched
//   Merges rename updates (dispatch) and commit writebacks (ROB) onto the
//   register-file write port. Renames are registered with latency 1; commits
//   are queued in ROB order and drained one per ready cycle. rdy=0 freezes
//   everything; a jp_wrong pulse drops that cycle's dispatch and suppresses
//   one drain slot, but never discards queued commits.
// Config macro:
//   CMT_BYPASS_EN  commit into an empty FIFO is written combinationally in
//                  the same cycle (not enqueued); disabled during jp_wrong.
// Ports:
//   clk, rst                           clock / async active-high reset
//   rdy, jp_wrong                      global stall / misprediction flush
//   disp_valid/rd/idx, disp_ready      rename request handshake
//   cmt_valid/rd/idx/val, cmt_ready    commit writeback handshake
//   upd, upd_rd, upd_idx               RF rename strobe
//   write, write_rd, write_idx, new_val RF writeback strobe
//   cmt_pending                        commit FIFO occupancy
module rf_update_sched
  import rf_update_sched_pkg::*;
#(
  parameter int unsigned CMT_DEPTH  = CMT_DEPTH_DEF,
  parameter int unsigned ROB_IDX_W  = ROB_IDX_W_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic                          jp_wrong,
  input  logic                          disp_valid,
  input  logic [REG_ADDR_W-1:0]         disp_rd,
  input  logic [ROB_IDX_W-1:0]          disp_idx,
  output logic                          disp_ready,
  input  logic                          cmt_valid,
  input  logic [REG_ADDR_W-1:0]         cmt_rd,
  input  logic [ROB_IDX_W-1:0]          cmt_idx,
  input  logic [DATA_W-1:0]             cmt_val,
  output logic                          cmt_ready,
  output logic                          upd,
  output logic [REG_ADDR_W-1:0]         upd_rd,
  output logic [ROB_IDX_W-1:0]          upd_idx,
  output logic                          write,
  output logic [REG_ADDR_W-1:0]         write_rd,
  output logic [ROB_IDX_W-1:0]          write_idx,
  output logic [DATA_W-1:0]             new_val,
  output logic [cnt_w(CMT_DEPTH)-1:0]   cmt_pending
);

  localparam int unsigned ENT_W = REG_ADDR_W + ROB_IDX_W + DATA_W;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENT_W-1:0]      head;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [ROB_IDX_W-1:0]  head_idx;
  logic [DATA_W-1:0]     head_val;
  logic                  disp_acc;
  logic                  cmt_acc;
  logic                  bypass;
  logic                  push;
  logic                  pop;

  logic                  write_q;
  logic [REG_ADDR_W-1:0] write_rd_q;
  logic [ROB_IDX_W-1:0]  write_idx_q;
  logic [DATA_W-1:0]     new_val_q;

  assign disp_ready = rdy & ~jp_wrong;
  assign cmt_ready  = rdy & ~fifo_full;
  assign disp_acc   = disp_valid & disp_ready;
  assign cmt_acc    = cmt_valid & cmt_ready;

  always_comb begin
    bypass = FALSE;
`ifdef CMT_BYPASS_EN
    bypass = cmt_acc & fifo_empty & ~jp_wrong;
`endif
  end

  assign push = cmt_acc & ~bypass;
  // Head is consumed every ready cycle except the flush cycle.
  assign pop  = rdy & ~jp_wrong & ~fifo_empty;

  assign {head_rd, head_idx, head_val} = head;

  rf_cmt_fifo #(
    .DEPTH (CMT_DEPTH),
    .WIDTH (ENT_W)
  ) u_cmt_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({cmt_rd, cmt_idx, cmt_val}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (cmt_pending)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd         <= FALSE;
      upd_rd      <= '0;
      upd_idx     <= '0;
      write_q     <= FALSE;
      write_rd_q  <= '0;
      write_idx_q <= '0;
      new_val_q   <= '0;
    end else if (rdy) begin
      upd <= disp_acc & (disp_rd != '0);
      if (disp_acc) begin
        upd_rd  <= disp_rd;
        upd_idx <= disp_idx;
      end
      // rd==0 entries still consume their slot, shown as write=0.
      if (pop) begin
        write_q     <= (head_rd != '0);
        write_rd_q  <= head_rd;
        write_idx_q <= head_idx;
        new_val_q   <= head_val;
      end else begin
        write_q <= FALSE;
      end
    end
  end

  always_comb begin
    write     = write_q;
    write_rd  = write_rd_q;
    write_idx = write_idx_q;
    new_val   = new_val_q;
    if (bypass) begin
      write     = (cmt_rd != '0);
      write_rd  = cmt_rd;
      write_idx = cmt_idx;
      new_val   = cmt_val;
    end
  end

endmodule
